mult_result_bcd: RTL and testbench
==================================

Name: mult_result_bcd

Overview:
- Downstream stage of the 6-bit signed-magnitude multiplier.
- Consumes the multiplier's 12-bit magnitude result and sign flag, and converts the magnitude to 4 packed BCD digits using a sequential double-dabble algorithm (one bit per clock).
- Latches the sign and presents a stable, display-ready result to the 7-segment/display logic.
- Handshakes with the same start-style control used by the multiplier.

Parameters:
- WIDTH, 12, binary magnitude width; must equal the multiplier result width.
- DIGITS, 4, number of BCD digits; 10^DIGITS must be greater than 2^WIDTH - 1.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  level request: convert the current c/neg (from multiplier).
- c  input  WIDTH  unsigned magnitude from multiplier.
- neg  input  1  sign from multiplier (1 = negative).
- bcd  output  4*DIGITS  packed BCD, [3:0] = units, [7:4] = tens, [11:8] = hundreds, [15:12] = thousands.
- sign  output  1  latched sign, forced to 0 when the magnitude is 0.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when bcd/sign are updated.

Behaviour:
- Reset (async, any state): state=IDLE, bcd=0, sign=0, busy=0, done=0, internal shift register and counter cleared. Reset mid-conversion aborts it; no partial result ever appears on bcd.
- States: IDLE, SHIFT, FINISH, HOLD.
- IDLE: on an edge with start=1:
  - capture c into the binary shift register and neg into a sign latch;
  - clear the BCD working register; counter=0; busy=1; go to SHIFT.
  - c/neg are sampled only at this edge; later changes are ignored.
- SHIFT, one edge per input bit:
  - every working nibble >= 5 gets +3;
  - the combined {bcd_work, bin} shifts left 1 and the bin MSB enters the units LSB;
  - counter++; after the WIDTH-th shift go to FINISH.
  - Exactly WIDTH cycles in SHIFT.
- FINISH, one cycle:
  - bcd <= bcd_work;
  - sign <= neg_latched AND (captured c != 0);
  - done=1 for this cycle only; busy=0; go to HOLD.
- HOLD: wait for start=0, then go to IDLE. Holding start high does not retrigger. bcd/sign hold their last value indefinitely.
- Latency: start sampled at edge N → done high and bcd valid after edge N+WIDTH+1 (13 cycles at default). First new conversion possible 1 cycle after start falls.
- busy is high from edge N through edge N+WIDTH and low in FINISH, HOLD and IDLE.
- Arithmetic:
  - the +3 correction is a 4-bit add, applied before the shift in the same cycle;
  - the working register is 4*DIGITS bits and has no overflow at the defaults (max 4095 → 4/0/9/5).
- Inputs c above 3969 (outside the multiplier's range) still convert correctly up to 4095.
- start asserted simultaneously with reset release: reset wins; start is evaluated on the first edge after rst=0.
- start toggling during SHIFT/FINISH: ignored. The only effect is whether HOLD exits immediately.
- Outputs are registered; there is no combinational path from the inputs to the outputs.

Test Plan:
- Reset: assert rst mid-SHIFT (converting c=200) → bcd=0x0000, sign=0, busy=0, done=0 immediately (asynchronous). After release, with start low, the block stays IDLE.
- Positive: c=200, neg=0, start=1 held for 15 cycles → done pulses exactly once, 13 cycles after the start edge. bcd=0x0200, sign=0; no second done while start is held.
- Negative: c=63, neg=1 (9 × −7) → bcd=0x0063, sign=1. Changing c to 5 during SHIFT leaves the result unaffected.
- Boundaries:
  - c=0, neg=1 → bcd=0x0000, sign=0 (negative zero suppressed);
  - c=4095 → bcd=0x4095;
  - c=3969 → bcd=0x3969.
- Back-to-back: convert c=9, drop start for 1 cycle, then convert c=1234 neg=1 → first bcd=0x0009, then bcd=0x1234 sign=1. Each conversion gives exactly one done pulse and busy high for exactly 12 cycles.
- Exhaustive sweep: all c in 0..4095 with random neg → bcd matches the decimal digits of c and sign matches the rule above.

Source files
------------

// File: rtl/mult_result_bcd_if.sv
// Handshake and result bundle between the multiplier-side controller and the BCD result stage.
interface mult_result_bcd_if #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      c;
    logic                  neg;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign;
    logic                  busy;
    logic                  done;

    modport master (
        output start, c, neg,
        input  bcd, sign, busy, done
    );

    modport slave (
        input  start, c, neg,
        output bcd, sign, busy, done
    );
endinterface

// File: rtl/mult_result_bcd.sv
// Converts the multiplier's magnitude to packed BCD (double-dabble, one bit per clock)
// and presents a latched, display-ready sign/result.
module mult_result_bcd #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mult_result_bcd_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, HOLD} state_t;

    state_t                state, state_nx;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   work, work_adj;
    logic [CNT_W-1:0]      cnt;
    logic                  neg_l, nz;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  sign_q, busy_q, done_q;
    logic                  busy_nx, done_nx;
    logic                  last_shift;

    assign last_shift = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last_shift) state_nx = FINISH;
            FINISH:  state_nx = HOLD;
            HOLD:    if (!bus.start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Flags are registered from the upcoming state so they line up with the state they describe.
    always_comb begin
        busy_nx = (state_nx == SHIFT);
        done_nx = (state == FINISH);
    end

    always_comb begin
        logic [3:0] nib;
        work_adj = work;
        nib      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = work[4*i +: 4];
            work_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin    <= '0;
            work   <= '0;
            cnt    <= '0;
            neg_l  <= 1'b0;
            nz     <= 1'b0;
            bcd_q  <= '0;
            sign_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_nx;
            done_q <= done_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin   <= bus.c;
                        neg_l <= bus.neg;
                        nz    <= |bus.c;
                        work  <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    {work, bin} <= {work_adj, bin} << 1;
                    cnt         <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    bcd_q  <= work;
                    sign_q <= neg_l & nz;
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.sign = sign_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mult_result_bcd.sv
// Directed and sweep checks for mult_result_bcd against hand-computed decimal results.
module tb_mult_result_bcd;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    mult_result_bcd_if #(.WIDTH(12), .DIGITS(4)) bus ();

    mult_result_bcd #(.WIDTH(12), .DIGITS(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // lat counts edges after the start-sampling edge until done is seen.
    task automatic convert(input logic [11:0] cv, input logic nv, input int hold,
                           input int chg_at, input logic [11:0] chg_c,
                           output int lat, output int ndone, output int nbusy);
        lat = -1; ndone = 0; nbusy = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.c = cv; bus.neg = nv;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = k - 1;
            end
            if (bus.busy) nbusy++;
            if (k == chg_at) bus.c = chg_c;
            if (k == hold) bus.start = 1'b0;
            if (lat >= 0 && k >= hold + 1) break;
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        if (bus.done) ndone++;
    endtask

    int lat, nd, nb, cnt_d, cnt_b;
    logic nv;

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.c = '0; bus.neg = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bcd",  bus.bcd,  16'h0000);
        chk("rst_flags", {bus.sign, bus.busy, bus.done}, 3'b000);
        rst = 1'b0;
        @(negedge clk);

        convert(12'd200, 1'b0, 15, 0, 12'd0, lat, nd, nb);
        chk("pos_bcd",   bus.bcd, 16'h0200);
        chk("pos_sign",  bus.sign, 1'b0);
        chk("pos_lat",   lat, 32'd13);
        chk("pos_ndone", nd, 32'd1);
        chk("pos_nbusy", nb, 32'd12);

        // Abort mid-conversion: outputs must clear without waiting for an edge.
        @(negedge clk);
        bus.start = 1'b1; bus.c = 12'd200; bus.neg = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_bcd",   bus.bcd, 16'h0000);
        chk("arst_flags", {bus.sign, bus.busy, bus.done}, 3'b000);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt_d = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.done) cnt_d++;
            if (bus.busy) cnt_b++;
        end
        chk("idle_after_rst", {cnt_d[7:0], cnt_b[7:0], bus.bcd}, 32'h0000_0000);

        convert(12'd63, 1'b1, 1, 3, 12'd5, lat, nd, nb);
        chk("neg_bcd",  bus.bcd, 16'h0063);
        chk("neg_sign", bus.sign, 1'b1);

        convert(12'd0, 1'b1, 1, 0, 12'd0, lat, nd, nb);
        chk("zero_bcd",  bus.bcd, 16'h0000);
        chk("zero_sign", bus.sign, 1'b0);

        convert(12'd4095, 1'b0, 1, 0, 12'd0, lat, nd, nb);
        chk("max_bcd", bus.bcd, 16'h4095);

        convert(12'd3969, 1'b1, 1, 0, 12'd0, lat, nd, nb);
        chk("b3969_bcd",  bus.bcd, 16'h3969);
        chk("b3969_sign", bus.sign, 1'b1);

        convert(12'd9, 1'b0, 1, 0, 12'd0, lat, nd, nb);
        chk("b2b1_bcd",   {bus.sign, bus.bcd}, 17'h0_0009);
        chk("b2b1_done",  nd, 32'd1);
        chk("b2b1_busy",  nb, 32'd12);
        convert(12'd1234, 1'b1, 1, 0, 12'd0, lat, nd, nb);
        chk("b2b2_bcd",   {bus.sign, bus.bcd}, 17'h1_1234);
        chk("b2b2_done",  nd, 32'd1);
        chk("b2b2_busy",  nb, 32'd12);
        chk("b2b2_lat",   lat, 32'd13);

        for (int v = 0; v < 4096; v++) begin
            nv = 1'($urandom_range(0, 1));
            convert(v[11:0], nv, 1, 0, 12'd0, lat, nd, nb);
            chk("sweep", {bus.sign, bus.bcd}, {(nv && v != 0), to_bcd(v)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
